memarbiter: RTL and testbench
=============================

# memarbiter

Two-port arbiter and sequencer for the data memory (`memdata`). It sits between the CPU load/store unit (port 0) and a secondary master such as DMA or the debug loader (port 1). It serialises their word accesses onto the single memory port using a req/ack handshake with round-robin priority. Misaligned and out-of-range accesses are rejected with an error response and never reach the memory.

## Interface

Parameters:
- `WIDTH`, default `` `WORDSIZE `` (64): data/address width; must be a multiple of 8.
- `DEPTH`, default `` `MEMDATASIZE ``: memory size in bytes, used for the range check.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high. Same net as `memdata.reset`.
- `req0`, `req1` in 1: per-port access request.
- `we0`, `we1` in 1: 1 = store, 0 = load. Held stable while req is high.
- `addr0`, `addr1` in WIDTH: byte address. Held stable while req is high.
- `wdata0`, `wdata1` in WIDTH: store data. Held stable while req is high.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `err0`, `err1` out 1: valid only with ack. 1 = access rejected.
- `rdata` out WIDTH: load data, shared by both ports. Valid only with the matching ack.
- `mem_addr` out WIDTH: to `memdata.addr`.
- `mem_in` out WIDTH: to `memdata.in`.
- `mem_rden` out 1: to `memdata.rden`.
- `mem_wren` out 1: to `memdata.wren`.
- `mem_out` in WIDTH: from `memdata.out`. Combinational, big-endian 8-byte word.

## Operation

- State machine: IDLE, ACCESS, RESP. Registers: `state`, `sel` (granted port), `prio` (port favoured on conflict), `bad` (error flag).
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requesting: grant `prio`.
  - On grant, latch `sel`, `mem_addr`, `mem_in`, the write flag, and `bad`.
  - Go to ACCESS.
- `bad` = (addr[2:0] != 0) OR (addr > DEPTH-8).
  - Compare in WIDTH bits. No wrap: an address near 2^WIDTH-1 is out of range.
- ACCESS, exactly one cycle:
  - If not `bad`: `mem_rden` = 1 for a load, `mem_wren` = 1 for a store.
  - If `bad`: both enables stay 0.
  - Load: capture `mem_out` into the `rdata` register at the end of the cycle.
  - Store: `rdata` is loaded with 0.
  - `prio` toggles to the other port (`!sel`). Go to RESP.
- RESP, exactly one cycle:
  - `ack[sel]` = 1, and `err[sel]` = `bad`.
  - `rdata` = 0 when `bad`.
  - Go to IDLE.
- Requests are sampled only in IDLE. A req still high in the cycle after its ack is a new request.
- Only one ack is ever high. The non-granted port's ack/err stay 0.
- A requester must not change we/addr/wdata or drop req before its ack. Behaviour if it does is undefined.

## Timing

- Reset (synchronous) sets:
  - state = IDLE, prio = 0, sel = 0, bad = 0.
  - ack0/ack1/err0/err1 = 0, mem_rden = mem_wren = 0, rdata = 0, mem_addr = 0, mem_in = 0.
- Reset overrides any state. An access in ACCESS or RESP is abandoned with no ack, and the requester must reissue it. `memdata` reloads its image on the same edge, so a store in flight is lost.
- Latency: req high at edge N (IDLE) → ACCESS in cycle N+1 → ack in cycle N+2.
- Throughput: one access per 3 cycles. A port held continuously against a competing port gets every other slot.
- `mem_rden`/`mem_wren` are registered, asserted only in ACCESS, never both, never in IDLE/RESP.
- `mem_addr`/`mem_in` are stable for the whole ACCESS cycle. They hold their last value otherwise.
- The store commits on the edge closing ACCESS. A load issued afterwards from either port returns the new data.
- ack/err/rdata are registered. There are no combinational paths from inputs to outputs.

## Test plan

- Port 0 load from addr 0x10, memory holds 0x0102030405060708 there: ack0 in cycle N+2, err0 = 0, rdata = 0x0102030405060708. mem_rden high only in N+1.
- Port 1 store 0xDEADBEEFCAFEF00D to 0x20, then port 0 load from 0x20: second ack0 gives rdata = 0xDEADBEEFCAFEF00D. mem_wren pulses exactly once.
- Both ports request at once after reset and hold req for 4 accesses: grant order is 0,1,0,1, with acks 3 cycles apart and never simultaneous.
- Port 0 load from 0x13 (misaligned), then from DEPTH-4: each gives ack0 with err0 = 1 and rdata = 0. mem_rden/mem_wren stay 0 throughout.
- Reset asserted during the ACCESS of a port 1 store: no ack1, all outputs return to reset values next cycle. After reset, the target word equals the data file image.
- Port 0 keeps req high across its ack, with port 1 idle: the next access starts in the cycle after ack (back in IDLE), giving 3-cycle spacing.

Source files
------------

// File: rtl/memarbiter.sv
// Two-port round-robin arbiter sequencing word loads/stores onto the single data memory port.
// Misaligned or out-of-range accesses are answered with an error and never reach the memory.
`ifndef WORDSIZE
`define WORDSIZE 64
`endif
`ifndef MEMDATASIZE
`define MEMDATASIZE 1024
`endif

module memarbiter #(
  parameter int WIDTH = `WORDSIZE,
  parameter int DEPTH = `MEMDATASIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_in,
  output logic             mem_rden,
  output logic             mem_wren,
  input  logic [WIDTH-1:0] mem_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(DEPTH - 8);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             prio_q, prio_d;
  logic             bad_q, bad_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_in_q, mem_in_d;
  logic             mem_rden_q, mem_rden_d;
  logic             mem_wren_q, mem_wren_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;

  logic             grant;
  logic             g_we;
  logic             g_bad;
  logic [WIDTH-1:0] g_addr;
  logic [WIDTH-1:0] g_wdata;

  always_comb begin
    // A lone requester wins outright; prio only breaks ties.
    grant   = (req0 && req1) ? prio_q : req1;
    g_we    = grant ? we1 : we0;
    g_addr  = grant ? addr1 : addr0;
    g_wdata = grant ? wdata1 : wdata0;
    g_bad   = (g_addr[2:0] != 3'b000) || (g_addr > LAST_ADDR);
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    prio_d     = prio_q;
    bad_d      = bad_q;
    we_d       = we_q;
    mem_addr_d = mem_addr_q;
    mem_in_d   = mem_in_q;
    mem_rden_d = 1'b0;
    mem_wren_d = 1'b0;
    rdata_d    = rdata_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d      = grant;
          we_d       = g_we;
          bad_d      = g_bad;
          mem_addr_d = g_addr;
          mem_in_d   = g_wdata;
          // Enables are registered so they are high exactly during ACCESS.
          mem_rden_d = !g_bad && !g_we;
          mem_wren_d = !g_bad && g_we;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (bad_q || we_q) ? '0 : mem_out;
        prio_d  = !sel_q;
        ack0_d  = !sel_q;
        ack1_d  = sel_q;
        err0_d  = !sel_q && bad_q;
        err1_d  = sel_q && bad_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      prio_q     <= 1'b0;
      bad_q      <= 1'b0;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
      mem_rden_q <= 1'b0;
      mem_wren_q <= 1'b0;
      rdata_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      prio_q     <= prio_d;
      bad_q      <= bad_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      mem_in_q   <= mem_in_d;
      mem_rden_q <= mem_rden_d;
      mem_wren_q <= mem_wren_d;
      rdata_q    <= rdata_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign rdata    = rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_in   = mem_in_q;
  assign mem_rden = mem_rden_q;
  assign mem_wren = mem_wren_q;

endmodule

// File: tb/tb_memarbiter.sv
// Bench for memarbiter: vector table plus multi-cycle sequences, checked through an ack scoreboard.
module tb_memarbiter;

  localparam int W = 64;
  localparam int D = 256;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, we0, we1;
  logic [W-1:0] addr0, addr1, wdata0, wdata1;
  logic         ack0, ack1, err0, err1;
  logic [W-1:0] rdata, mem_addr, mem_in, mem_out;
  logic         mem_rden, mem_wren;

  int vec_cnt  = 0;
  int miscomp  = 0;
  int wren_cnt = 0;

  always #5 clk = ~clk;

  memarbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_out(mem_out)
  );

  function automatic logic [63:0] img(input int i);
    if (i == 2) return 64'h0102_0304_0506_0708;
    return {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
  endfunction

  // Data memory stand-in: combinational read, write on the edge, image reload on reset.
  logic [63:0] mem [32];
  assign mem_out = mem[5'(mem_addr >> 3)];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= img(i);
    end else if (mem_wren) begin
      mem[5'(mem_addr >> 3)] <= mem_in;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    bit          err;
    logic [63:0] rdata;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (mem_wren === 1'b1) wren_cnt++;
    if (mem_rden === 1'b1 && mem_wren === 1'b1) begin
      miscomp++;
      $display("FAIL both_enables: rden=1 wren=1 required at most one");
    end
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      chk("ack_exclusive", {63'b0, ack0 & ack1}, 64'd0);
      if (sbq.size() == 0) begin
        miscomp++;
        $display("FAIL unexpected_ack: ack0=%b ack1=%b with nothing outstanding", ack0, ack1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ack_port", {63'b0, ack1}, {63'b0, e.port});
        chk("err", {63'b0, ack1 ? err1 : err0}, {63'b0, e.err});
        chk("err_other", {63'b0, ack1 ? err0 : err1}, 64'd0);
        chk("rdata", rdata, e.rdata);
      end
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          exp_err;
    logic [63:0] exp_rdata;
  } vec_t;
  vec_t tbl[14];

  task automatic drive(input bit port, input bit we, input logic [63:0] a, input logic [63:0] d);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  // Starts on a negedge in IDLE; returns on a negedge in IDLE.
  task automatic do_access(input vec_t v);
    int n;
    bit got;
    exp_t e;
    e.port = v.port; e.err = v.exp_err; e.rdata = v.exp_rdata;
    sbq.push_back(e);
    drive(v.port, v.we, v.addr, v.wdata);
    got = 1'b0;
    n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("rden_access", {63'b0, mem_rden}, {63'b0, !v.exp_err && !v.we});
        chk("wren_access", {63'b0, mem_wren}, {63'b0, !v.exp_err && v.we});
      end
      if ((v.port ? ack1 : ack0) === 1'b1) got = 1'b1;
    end
    chk("ack_latency", 64'(n), 64'd2);
    chk("enables_resp", {62'b0, mem_rden, mem_wren}, 64'd0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("ack_cleared", {62'b0, ack0, ack1}, 64'd0);
  endtask

  // Requests already driven in IDLE; expects acks at cycles 2, 5, 8, ...
  task automatic held_run(input int n_acks);
    int k = 0;
    for (int t = 1; t <= 40 && k < n_acks; t++) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        chk("ack_spacing", 64'(t), 64'(2 + 3 * k));
        k++;
        if (k == n_acks) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    chk("held_ack_count", 64'(k), 64'(n_acks));
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    tbl[0]  = '{0, 0, 64'h10, 64'h0, 0, 64'h0102_0304_0506_0708};
    tbl[1]  = '{1, 1, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h0};
    tbl[2]  = '{0, 0, 64'h20, 64'h0, 0, 64'hDEAD_BEEF_CAFE_F00D};
    tbl[3]  = '{0, 0, 64'h13, 64'h0, 1, 64'h0};
    tbl[4]  = '{0, 0, 64'(D - 4), 64'h0, 1, 64'h0};
    tbl[5]  = '{1, 0, 64'(D - 8), 64'h0, 0, img(31)};
    tbl[6]  = '{1, 1, 64'h30, 64'h0011_2233_4455_6677, 0, 64'h0};
    tbl[7]  = '{1, 0, 64'h30, 64'h0, 0, 64'h0011_2233_4455_6677};
    tbl[8]  = '{0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1, 64'h0};
    tbl[9]  = '{1, 1, 64'h29, 64'h1234_5678_9ABC_DEF0, 1, 64'h0};
    tbl[10] = '{0, 0, 64'h28, 64'h0, 0, img(5)};
    tbl[11] = '{0, 0, 64'(D), 64'h0, 1, 64'h0};
    tbl[12] = '{0, 1, 64'h40, 64'hCAFE_0000_BEEF_1111, 0, 64'h0};
    tbl[13] = '{1, 0, 64'h40, 64'h0, 0, 64'hCAFE_0000_BEEF_1111};

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {58'b0, ack0, ack1, err0, err1, mem_rden, mem_wren}, 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    wren_cnt = 0;

    for (int i = 0; i < 14; i++) do_access(tbl[i]);
    chk("wren_pulses", 64'(wren_cnt), 64'd3);

    // Reset lands on the edge closing a port 1 store's ACCESS cycle.
    drive(1'b1, 1'b1, 64'h20, 64'h7777_6666_5555_4444);
    @(negedge clk);
    chk("rst_wren_in_access", {63'b0, mem_wren}, 64'd1);
    reset = 1'b1;
    req1 = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {58'b0, ack0, ack1, err0, err1, mem_rden, mem_wren}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_in", mem_in, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_ack", {62'b0, ack0, ack1}, 64'd0);
    do_access('{0, 0, 64'h20, 64'h0, 0, img(4)});

    // Both ports held after reset: grants alternate 0,1,0,1.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      e = '{0, 0, 64'h0102_0304_0506_0708}; sbq.push_back(e);
      e = '{1, 0, img(3)};                  sbq.push_back(e);
    end
    drive(1'b0, 1'b0, 64'h10, 64'h0);
    drive(1'b1, 1'b0, 64'h18, 64'h0);
    held_run(4);

    // Port 0 keeps req across its ack: back-to-back accesses 3 cycles apart.
    for (int k = 0; k < 2; k++) begin
      e = '{0, 0, 64'h0102_0304_0506_0708}; sbq.push_back(e);
    end
    drive(1'b0, 1'b0, 64'h10, 64'h0);
    held_run(2);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
    $finish;
  end

endmodule
